// File: rtl/btn_pkg.sv
// Shared state encoding and click event codes for the button gesture decoder.
// The LCD controller imports the same event constants.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    localparam logic [1:0] EVT_NONE   = 2'b00;
    localparam logic [1:0] EVT_SINGLE = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_TRIPLE = 2'b11;

    // Click count increment that holds at the ceiling instead of wrapping.
    function automatic logic [1:0] sat_inc(input logic [1:0] cnt, input logic [1:0] ceiling);
        return (cnt >= ceiling) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/btn_click_decoder_if.sv
// Pulse-in / event-out bundle between the debouncer, the click decoder and its consumer.
interface btn_click_decoder_if;

    logic       btn_pulse;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       busy;

    modport master (
        output btn_pulse,
        input  evt_valid,
        input  evt_code,
        input  busy
    );

    modport slave (
        input  btn_pulse,
        output evt_valid,
        output evt_code,
        output busy
    );

endinterface

// File: rtl/click_window_timer.sv
// Inter-click window counter: cleared on demand, counts while enabled and
// parks at WINDOW_TICKS-1 where expired_o is flagged.
module click_window_timer #(
    parameter int unsigned WINDOW_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(WINDOW_TICKS);
    localparam logic [TW-1:0] LAST = TW'(WINDOW_TICKS - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign expired_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/btn_click_decoder.sv
// Groups debounced button pulses into single/double/triple click gestures and
// strobes one registered event code per completed gesture.
module btn_click_decoder
    import btn_pkg::*;
#(
    parameter int unsigned WINDOW_TICKS = 25_000_000,
    parameter int unsigned MAX_CLICKS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_click_decoder_if.slave   bus
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_CLICKS);

    state_t     state_q;
    logic [1:0] click_cnt_q;
    logic       evt_valid_q;
    logic [1:0] evt_code_q;
    logic       busy_q;

    logic       expired;
    logic       tmr_clear;
    logic       tmr_enable;
    logic [1:0] cnt_inc;

    assign cnt_inc    = sat_inc(click_cnt_q, MAX_CNT);
    assign tmr_enable = (state_q == COUNT);
    // Outside COUNT the timer is held at zero so every new gesture starts a fresh window.
    assign tmr_clear  = bus.btn_pulse || (state_q != COUNT);

    click_window_timer #(
        .WINDOW_TICKS (WINDOW_TICKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_enable),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            click_cnt_q <= 2'd0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= EVT_NONE;
            busy_q      <= 1'b0;
        end else begin
            evt_valid_q <= (state_q == EMIT);
            evt_code_q  <= (state_q == EMIT) ? click_cnt_q : EVT_NONE;
            busy_q      <= (state_q == COUNT);

            case (state_q)
                IDLE: begin
                    if (bus.btn_pulse) begin
                        state_q     <= COUNT;
                        click_cnt_q <= 2'd1;
                    end
                end
                COUNT: begin
                    // A pulse coinciding with expiry still extends the gesture.
                    if (bus.btn_pulse) begin
                        click_cnt_q <= cnt_inc;
                        if (cnt_inc == MAX_CNT) begin
                            state_q <= EMIT;
                        end
                    end else if (expired) begin
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.btn_pulse) begin
                        state_q     <= COUNT;
                        click_cnt_q <= 2'd1;
                    end else begin
                        state_q     <= IDLE;
                        click_cnt_q <= 2'd0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    click_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_code  = evt_code_q;
    assign bus.busy      = busy_q;

endmodule
